// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite encodings for the DMAC channel master and the memory responder.
// Both ends import this package so they agree on transfer, response and size codes.
package dmac_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

  // The data bus is 32 bits wide, so nothing wider than a word can be served.
  function automatic logic hsize_legal(input logic [2:0] size);
    return (size <= HSIZE_WORD);
  endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite slave-side bus bundle between the DMAC channel master and the memory responder.
interface ahb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              HSel;
  logic [ADDR_W-1:0] HAddr;
  logic [1:0]        HTrans;
  logic              HWrite;
  logic [2:0]        HSize;
  logic [DATA_W-1:0] HWData;
  logic              HReady;
  logic              HReadyOut;
  logic [1:0]        HResp;
  logic [DATA_W-1:0] HRData;

  modport master (
    output HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
    input  HReadyOut, HResp, HRData
  );

  modport slave (
    input  HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
    output HReadyOut, HResp, HRData
  );

endinterface

// File: rtl/ahb_byte_strobe.sv
// Maps an AHB transfer size and the low address bits onto the four byte lanes
// of a little-endian 32-bit word, flagging accesses not aligned to their size.
module ahb_byte_strobe
  import dmac_ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] lane_en,
  output logic       misalign
);

  // Lane decode; sizes above a word are rejected by the caller, not here.
  always_comb begin
    lane_en  = 4'b0000;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: begin
        lane_en  = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      HSIZE_HALF: begin
        lane_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        lane_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        lane_en  = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite responder backing a word-addressed SRAM with programmable wait states
// and a two-cycle ERROR response for out-of-window, oversize or misaligned accesses.
module ahb_mem_slave
  import dmac_ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int BASE_ADDR   = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  ahb_mem_slave_if.slave  bus
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam int                LANES     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH * 4);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

  slv_state_t        state_r, state_s;
  logic [3:0]        wcnt_r, wcnt_s;
  logic [IDX_W-1:0]  idx_r;
  logic              write_r;
  logic [3:0]        lane_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [ADDR_W-1:0] off_s;
  logic [3:0]        lane_en_s;
  logic              misalign_s;
  logic              accept_s;
  logic              capture_s;
  logic              legal_s;
  logic              complete_s;
  logic              ready_s;
  logic [1:0]        resp_s;
  logic [DATA_W-1:0] rdata_s;

  ahb_byte_strobe u_strobe (
    .size     (bus.HSize),
    .addr_lo  (bus.HAddr[1:0]),
    .lane_en  (lane_en_s),
    .misalign (misalign_s)
  );

  // A new address phase is only taken when no data phase is still stalling;
  // an underflowing offset (below BASE) lands far outside the window.
  assign off_s      = bus.HAddr - BASE;
  assign accept_s   = (state_r == ST_IDLE) || (state_r == ST_ERR2) ||
                      ((state_r == ST_DATA) && (wcnt_r == 4'd0));
  assign capture_s  = bus.HSel && bus.HReady && bus.HTrans[1] && accept_s;
  assign legal_s    = (off_s < WIN_BYTES) && hsize_legal(bus.HSize) && !misalign_s;
  assign complete_s = (state_r == ST_DATA) && (wcnt_r == 4'd0);

  // State register, wait counter and address-phase capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 4'd0;
      idx_r   <= '0;
      write_r <= 1'b0;
      lane_r  <= 4'b0000;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
      if (capture_s) begin
        idx_r   <= off_s[IDX_W+1:2];
        write_r <= bus.HWrite;
        lane_r  <= lane_en_s;
      end
    end
  end

  // Next-state logic; a completing data phase may overlap the next address phase.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (capture_s) begin
          state_s = legal_s ? ST_DATA : ST_ERR1;
          wcnt_s  = legal_s ? WAIT_INIT : 4'd0;
        end else begin
          state_s = ST_IDLE;
          wcnt_s  = 4'd0;
        end
      end
      ST_DATA: begin
        if (wcnt_r != 4'd0) begin
          state_s = ST_DATA;
          wcnt_s  = wcnt_r - 4'd1;
        end else if (capture_s) begin
          state_s = legal_s ? ST_DATA : ST_ERR1;
          wcnt_s  = legal_s ? WAIT_INIT : 4'd0;
        end else begin
          state_s = ST_IDLE;
          wcnt_s  = 4'd0;
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
        wcnt_s  = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        wcnt_s  = 4'd0;
      end
    endcase
  end

  // Write commit at the edge ending the data phase; reset drops a pending write.
  always_ff @(posedge clk) begin
    if (rst && complete_s && write_r) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_r[i]) begin
          mem_r[idx_r][8*i +: 8] <= bus.HWData[8*i +: 8];
        end
      end
    end
  end

  // Response outputs decoded from registered state only.
  always_comb begin
    ready_s = 1'b1;
    resp_s  = HRESP_OKAY;
    rdata_s = '0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        resp_s  = HRESP_OKAY;
      end
      ST_DATA: begin
        ready_s = (wcnt_r == 4'd0);
        resp_s  = HRESP_OKAY;
        if ((wcnt_r == 4'd0) && !write_r) begin
          rdata_s = mem_r[idx_r];
        end else begin
          rdata_s = '0;
        end
      end
      ST_ERR1: begin
        ready_s = 1'b0;
        resp_s  = HRESP_ERROR;
      end
      ST_ERR2: begin
        ready_s = 1'b1;
        resp_s  = HRESP_ERROR;
      end
      default: begin
        ready_s = 1'b1;
        resp_s  = HRESP_OKAY;
      end
    endcase
  end

  assign bus.HReadyOut = ready_s;
  assign bus.HResp     = resp_s;
  assign bus.HRData    = rdata_s;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: a one-wait-state instance for single transfers,
// errors and reset, and a zero-wait instance for the pipelined burst with BUSY.
module tb_ahb_mem_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = 32'h0;
  logic        hready_en = 1'b1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  assign bus1.HSel   = hsel;   assign bus0.HSel   = hsel;
  assign bus1.HAddr  = haddr;  assign bus0.HAddr  = haddr;
  assign bus1.HTrans = htrans; assign bus0.HTrans = htrans;
  assign bus1.HWrite = hwrite; assign bus0.HWrite = hwrite;
  assign bus1.HSize  = hsize;  assign bus0.HSize  = hsize;
  assign bus1.HWData = hwdata; assign bus0.HWData = hwdata;
  assign bus1.HReady = bus1.HReadyOut & hready_en;
  assign bus0.HReady = bus0.HReadyOut & hready_en;

  ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(0), .WAIT_STATES(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(0), .WAIT_STATES(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic [1:0] exp_resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
    vecs.push_back(v);
  endtask

  // Single non-pipelined transfer paced by the one-wait-state instance.
  task automatic do_xfer(input vec_t v, output logic [1:0] first_resp, output int waits,
                         output logic [1:0] resp, output logic [31:0] rdata);
    bit done;
    hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hsize = v.size;
    tick();
    first_resp = bus1.HResp;
    hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.HReadyOut) begin
        done = 1'b1;
        break;
      end
      tick();
      waits++;
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    resp  = bus1.HResp;
    rdata = bus1.HRData;
    tick();
  endtask

  initial begin
    logic [1:0]  fr, rs;
    logic [31:0] rd;
    int          w;
    vec_t        v;

    add(1'b1, 32'h010, 3'b010, 32'hDEADBEEF, 32'h0,        2'b00);
    add(1'b0, 32'h010, 3'b010, 32'h0,        32'hDEADBEEF, 2'b00);
    add(1'b1, 32'h020, 3'b010, 32'h11223344, 32'h0,        2'b00);
    add(1'b1, 32'h023, 3'b000, 32'hAB000000, 32'h0,        2'b00);
    add(1'b0, 32'h020, 3'b010, 32'h0,        32'hAB223344, 2'b00);
    add(1'b1, 32'h022, 3'b001, 32'hCCDD0000, 32'h0,        2'b00);
    add(1'b0, 32'h020, 3'b010, 32'h0,        32'hCCDD3344, 2'b00);
    add(1'b1, 32'h021, 3'b000, 32'h0000EE00, 32'h0,        2'b00);
    add(1'b0, 32'h020, 3'b010, 32'h0,        32'hCCDDEE44, 2'b00);
    add(1'b1, 32'h000, 3'b010, 32'h0F1E2D3C, 32'h0,        2'b00);
    add(1'b1, 32'h004, 3'b010, 32'h4B5A6978, 32'h0,        2'b00);
    add(1'b1, 32'h008, 3'b010, 32'h8796A5B4, 32'h0,        2'b00);
    add(1'b1, 32'h00C, 3'b010, 32'hC3D2E1F0, 32'h0,        2'b00);
    add(1'b1, 32'h3FC, 3'b010, 32'h5A5AA5A5, 32'h0,        2'b00);
    add(1'b0, 32'h3FC, 3'b010, 32'h0,        32'h5A5AA5A5, 2'b00);
    add(1'b1, 32'h401, 3'b010, 32'hFFFFFFFF, 32'h0,        2'b01);
    add(1'b1, 32'h400, 3'b010, 32'hFFFFFFFF, 32'h0,        2'b01);
    add(1'b1, 32'h022, 3'b010, 32'hFFFFFFFF, 32'h0,        2'b01);
    add(1'b1, 32'h021, 3'b001, 32'hFFFFFFFF, 32'h0,        2'b01);
    add(1'b0, 32'h020, 3'b011, 32'h0,        32'h0,        2'b01);
    add(1'b0, 32'h000, 3'b010, 32'h0,        32'h0F1E2D3C, 2'b00);
    add(1'b0, 32'h020, 3'b010, 32'h0,        32'hCCDDEE44, 2'b00);
    add(1'b1, 32'h030, 3'b010, 32'h55555555, 32'h0,        2'b00);

    // Reset state.
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    check("rst_ready1", {31'd0, bus1.HReadyOut}, 32'd1);
    check("rst_resp1",  {30'd0, bus1.HResp},     32'd0);
    check("rst_rdata1", bus1.HRData,             32'd0);
    check("rst_ready0", {31'd0, bus0.HReadyOut}, 32'd1);

    // Table: one wait state on every OKAY phase, ERROR is low-then-high with resp 01.
    foreach (vecs[k]) begin
      v = vecs[k];
      do_xfer(v, fr, w, rs, rd);
      check($sformatf("v%0d_first_resp", k), {30'd0, fr}, {30'd0, v.exp_resp});
      check($sformatf("v%0d_waits", k), w, 32'd1);
      check($sformatf("v%0d_resp", k), {30'd0, rs}, {30'd0, v.exp_resp});
      check($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
    end

    // Pipelined burst on the zero-wait instance with BUSY between beats 2 and 3.
    hsel = 1'b1; hwrite = 1'b0; hsize = 3'b010;
    htrans = 2'b10; haddr = 32'h0;
    tick();
    check("burst_b0_ready", {31'd0, bus0.HReadyOut}, 32'd1);
    check("burst_b0_data", bus0.HRData, 32'h0F1E2D3C);
    htrans = 2'b11; haddr = 32'h4;
    tick();
    check("burst_b1_data", bus0.HRData, 32'h4B5A6978);
    htrans = 2'b01; haddr = 32'h8;
    tick();
    check("burst_busy_ready", {31'd0, bus0.HReadyOut}, 32'd1);
    check("burst_busy_resp",  {30'd0, bus0.HResp},     32'd0);
    check("burst_busy_rdata", bus0.HRData,             32'd0);
    htrans = 2'b11; haddr = 32'h8;
    tick();
    check("burst_b2_data", bus0.HRData, 32'h8796A5B4);
    htrans = 2'b11; haddr = 32'hC;
    tick();
    check("burst_b3_data", bus0.HRData, 32'hC3D2E1F0);
    check("burst_b3_resp", {30'd0, bus0.HResp}, 32'd0);
    htrans = 2'b00; hsel = 1'b0;
    tick();
    check("burst_end_rdata", bus0.HRData, 32'd0);
    repeat (3) tick();

    // Reset during a write wait state drops the write.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'b010;
    tick();
    check("rstw_waiting", {31'd0, bus1.HReadyOut}, 32'd0);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678; rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rstw_ready", {31'd0, bus1.HReadyOut}, 32'd1);
    check("rstw_resp",  {30'd0, bus1.HResp},     32'd0);
    check("rstw_rdata", bus1.HRData,             32'd0);
    repeat (3) tick();
    v.wr = 1'b0; v.addr = 32'h30; v.size = 3'b010; v.wdata = 32'h0;
    do_xfer(v, fr, w, rs, rd);
    check("rstw_keep", rd, 32'h55555555);

    // HReady low blocks capture.
    hready_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'b010;
    hwdata = 32'h00000000;
    tick();
    check("nordy_ready", {31'd0, bus1.HReadyOut}, 32'd1);
    tick();
    check("nordy_ready2", {31'd0, bus1.HReadyOut}, 32'd1);
    hsel = 1'b0; htrans = 2'b00; hready_en = 1'b1;
    repeat (2) tick();
    do_xfer(v, fr, w, rs, rd);
    check("nordy_keep", rd, 32'h55555555);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
